// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, keyboard command bytes and frame helpers.
// Used by ps2_host_tx and by the device-to-host receiver (kb_interface).
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_DONE,
        ST_FAIL
    } ps2_state_e;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] ACK_BYTE     = 8'hFA;

    localparam int unsigned MAX_RETRIES = 2;

    // {stop, odd parity, data}; bit 0 is the first bit shifted onto the line.
    function automatic logic [9:0] frame_bits(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 line conditioning: 2-flop synchronizers on clock and data, a glitch filter
// on the clock, and a one-cycle falling-edge strobe of the filtered clock.
module ps2_line_sync #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_raw,
    input  logic ps2_data_raw,
    output logic clk_filt,
    output logic data_sync,
    output logic clk_fe
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_meta_q, clk_meta_d;
    logic [1:0]    data_meta_q, data_meta_d;
    logic [CW-1:0] flt_cnt_q, flt_cnt_d;
    logic          clk_filt_q, clk_filt_d;
    logic          fe_q, fe_d;

    // The filtered level flips only after FILTER_LEN consecutive samples disagree with it.
    always_comb begin
        clk_meta_d  = {clk_meta_q[0], ps2_clk_raw};
        data_meta_d = {data_meta_q[0], ps2_data_raw};
        clk_filt_d  = clk_filt_q;
        flt_cnt_d   = '0;
        if (clk_meta_q[1] != clk_filt_q) begin
            if (flt_cnt_q == CW'(FILTER_LEN - 1)) begin
                clk_filt_d = clk_meta_q[1];
            end else begin
                flt_cnt_d = flt_cnt_q + CW'(1);
            end
        end
        fe_d = clk_filt_q & ~clk_filt_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta_q  <= 2'b11;
            data_meta_q <= 2'b11;
            flt_cnt_q   <= '0;
            clk_filt_q  <= 1'b1;
            fe_q        <= 1'b0;
        end else begin
            clk_meta_q  <= clk_meta_d;
            data_meta_q <= data_meta_d;
            flt_cnt_q   <= flt_cnt_d;
            clk_filt_q  <= clk_filt_d;
            fe_q        <= fe_d;
        end
    end

    assign clk_filt  = clk_filt_q;
    assign data_sync = data_meta_q[1];
    assign clk_fe    = fe_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter (inhibit, request-to-send, 11-bit frame, ack).
// Optional: define PS2_HOST_TX_RETRY_EN to retry a failed frame up to MAX_RETRIES times.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 7800,
    parameter int unsigned TIMEOUT_CYCLES = 975000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic clk_filt, data_sync, clk_fe;

    ps2_line_sync #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_sync (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk_raw  (ps2_clk_in),
        .ps2_data_raw (ps2_data_in),
        .clk_filt     (clk_filt),
        .data_sync    (data_sync),
        .clk_fe       (clk_fe)
    );

    ps2_state_e    state_q, state_d;
    logic [9:0]    shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [IW-1:0] inh_cnt_q, inh_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          tmo_hit;
`ifdef PS2_HOST_TX_RETRY_EN
    logic [7:0]    byte_q, byte_d;
    logic [1:0]    retry_cnt_q, retry_cnt_d;
`endif

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        inh_cnt_d = inh_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        tmo_hit   = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
        byte_d      = byte_q;
        retry_cnt_d = retry_cnt_q;
`endif

        // Saturating count of cycles since the clock line was released.
        if (state_q inside {ST_REQ, ST_ACK, ST_WAIT_IDLE}) begin
            if (tmo_cnt_q != '1) begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
            tmo_hit = (tmo_cnt_d >= TW'(TIMEOUT_CYCLES));
        end

        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    state_d   = ST_INHIBIT;
                    shift_d   = frame_bits(tx_data);
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = (INHIBIT_CYCLES == 1);
`ifdef PS2_HOST_TX_RETRY_EN
                    byte_d      = tx_data;
                    retry_cnt_d = '0;
`endif
                end
            end
            ST_INHIBIT: begin
                inh_cnt_d = inh_cnt_q + IW'(1);
                if (32'(inh_cnt_q) + 32'd2 == INHIBIT_CYCLES) begin
                    data_oe_d = 1'b1;
                end
                if (32'(inh_cnt_q) + 32'd1 == INHIBIT_CYCLES) begin
                    state_d   = ST_REQ;
                    clk_oe_d  = 1'b0;
                    bit_cnt_d = '0;
                    tmo_cnt_d = '0;
                end
            end
            ST_REQ: begin
                if (tmo_hit) begin
                    state_d   = ST_FAIL;
                    data_oe_d = 1'b0;
                end else if (clk_fe) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b1, shift_q[9:1]};
                    if (bit_cnt_q == 4'd9) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (tmo_hit) begin
                    state_d   = ST_FAIL;
                    data_oe_d = 1'b0;
                end else if (clk_fe) begin
                    state_d = data_sync ? ST_FAIL : ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (tmo_hit) begin
                    state_d   = ST_FAIL;
                    data_oe_d = 1'b0;
                end else if (clk_filt && data_sync) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_FAIL: begin
                state_d   = ST_IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
                if (retry_cnt_q != 2'(MAX_RETRIES)) begin
                    state_d     = ST_INHIBIT;
                    retry_cnt_d = retry_cnt_q + 2'd1;
                    shift_d     = frame_bits(byte_q);
                    inh_cnt_d   = '0;
                    clk_oe_d    = 1'b1;
                    data_oe_d   = (INHIBIT_CYCLES == 1);
                end
`endif
            end
            default: begin
                state_d   = ST_IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            tmo_cnt_q <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            byte_q      <= '0;
            retry_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            inh_cnt_q <= inh_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
`ifdef PS2_HOST_TX_RETRY_EN
            byte_q      <= byte_d;
            retry_cnt_q <= retry_cnt_d;
`endif
        end
    end

    assign tx_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = (state_q == ST_DONE);
`ifdef PS2_HOST_TX_RETRY_EN
    assign tx_error    = (state_q == ST_FAIL) && (retry_cnt_q == 2'(MAX_RETRIES));
`else
    assign tx_error    = (state_q == ST_FAIL);
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and
// compares them with frames built from the protocol rules. Honors PS2_HOST_TX_RETRY_EN.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned INH = 200;
    localparam int unsigned TMO = 2500;
    localparam int unsigned FLT = 8;
`ifdef PS2_HOST_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_line, ps2_data_line;

    assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FLT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error)
    );

    int passed = 0;
    int total  = 0;

    // Bus statistics gathered every cycle
    int   cyc = 0, done_cnt = 0, err_cnt = 0, inhibit_phases = 0;
    int   inh_len = 0, last_inh_len = 0, viol = 0, req_cyc = 0, err_cyc = 0;
    logic prev_clk_oe = 1'b0, prev_both = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (tx_done) begin
            done_cnt++;
            if (!busy || tx_ready) viol++;
        end
        if (tx_error) begin
            err_cnt++;
            err_cyc = cyc;
            if (ps2_clk_oe || ps2_data_oe) viol++;
        end
        if (ps2_clk_oe && !prev_clk_oe) begin
            inhibit_phases++;
            inh_len = 1;
        end else if (ps2_clk_oe) begin
            inh_len++;
        end
        if (!ps2_clk_oe && prev_clk_oe) begin
            last_inh_len = inh_len;
            req_cyc = cyc;
        end
        if (prev_both && ps2_clk_oe) viol++;
        if (ps2_data_oe && !busy) viol++;
        prev_both   = ps2_clk_oe && ps2_data_oe;
        prev_clk_oe = ps2_clk_oe;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, got cycle %0d want finish", cyc);
        $fatal(1);
    end

    // Frame as the device should see it on rising edges: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] expected_frame(input logic [7:0] d);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = d[i];
            ones += int'(d[i]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send_req(input logic [7:0] d, output logic ok);
        int n;
        n = 0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = tx_ready;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic wait_idle(input int limit, output logic ok);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok = !busy;
        repeat (2) @(negedge clk);
    endtask

    // Device model: waits for the host's request, clocks 10 bits, then acks (or not) on clock 11.
    task automatic device_frame(input int half, input logic ack, input int glitch_at,
                                input int abort_at, output logic [10:0] bits, output logic ok);
        int n;
        ok   = 1'b1;
        bits = '0;
        n = 0;
        while (!ps2_clk_oe && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ps2_clk_oe) begin
            ok = 1'b0;
            return;
        end
        n = 0;
        while (ps2_clk_oe && n < int'(INH) + 300) begin
            @(negedge clk);
            n++;
        end
        if (ps2_clk_oe) begin
            ok = 1'b0;
            return;
        end
        repeat (half) @(negedge clk);
        bits[0] = ps2_data_line;
        for (int k = 1; k <= 10; k++) begin
            dev_clk_low = 1'b1;
            if (k == abort_at) begin
                repeat (FLT + 8) @(negedge clk);
                return;
            end
            repeat (half) @(negedge clk);
            dev_clk_low = 1'b0;
            bits[k] = ps2_data_line;
            if (k == glitch_at) begin
                repeat (half / 2) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (2) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (half - half / 2 - 2) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
        end
        dev_data_low = ack;
        repeat (2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (half) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (half / 2) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready: got %b want 1", tx_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (ps2_clk_oe !== 1'b0) $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); else passed++;
        total++; if (ps2_data_oe !== 1'b0) $display("FAIL reset_data_oe: got %b want 0", ps2_data_oe); else passed++;
        total++; if (tx_done !== 1'b0) $display("FAIL reset_tx_done: got %b want 0", tx_done); else passed++;
        total++; if (tx_error !== 1'b0) $display("FAIL reset_tx_error: got %b want 0", tx_error); else passed++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ack_frame(input logic [7:0] d, input int glitch_at);
        int          d0, e0, i0, v0, half;
        logic [10:0] bits, exp;
        logic        ok_req, ok_bfm, ok_idle;
        half = int'($urandom_range(25, 40));
        d0 = done_cnt; e0 = err_cnt; i0 = inhibit_phases; v0 = viol;
        exp = expected_frame(d);
        send_req(d, ok_req);
        device_frame(half, 1'b1, glitch_at, 0, bits, ok_bfm);
        wait_idle(int'(TMO), ok_idle);
        total++; if (!(ok_req && ok_bfm && ok_idle))
            $display("FAIL frame_%h_handshake: got req=%b bus=%b idle=%b want 111", d, ok_req, ok_bfm, ok_idle); else passed++;
        total++; if (bits !== exp) $display("FAIL frame_%h_bits: got %b want %b", d, bits, exp); else passed++;
        total++; if (done_cnt - d0 != 1) $display("FAIL frame_%h_done: got %0d pulses want 1", d, done_cnt - d0); else passed++;
        total++; if (err_cnt - e0 != 0) $display("FAIL frame_%h_error: got %0d pulses want 0", d, err_cnt - e0); else passed++;
        total++; if (inhibit_phases - i0 != 1) $display("FAIL frame_%h_inhibits: got %0d want 1", d, inhibit_phases - i0); else passed++;
        total++; if (last_inh_len != int'(INH)) $display("FAIL frame_%h_inhibit_len: got %0d want %0d", d, last_inh_len, INH); else passed++;
        total++; if (viol - v0 != 0) $display("FAIL frame_%h_line_rules: got %0d violations want 0", d, viol - v0); else passed++;
        total++; if (tx_ready !== 1'b1) $display("FAIL frame_%h_ready_after: got %b want 1", d, tx_ready); else passed++;
    endtask

    task automatic test_random_frames();
        for (int i = 0; i < 4; i++) test_ack_frame(8'($urandom), 0);
    endtask

    task automatic test_glitch();
        test_ack_frame(8'($urandom), int'($urandom_range(2, 8)));
    endtask

    task automatic test_nack();
        int          d0, e0, i0, half;
        logic [10:0] bits, first_bits;
        logic        ok_req, ok_bfm, ok_all, ok_idle;
        d0 = done_cnt; e0 = err_cnt; i0 = inhibit_phases;
        half = int'($urandom_range(25, 40));
        ok_all = 1'b1;
        first_bits = '0;
        send_req(CMD_RESET, ok_req);
        for (int a = 0; a < ATTEMPTS; a++) begin
            device_frame(half, 1'b0, 0, 0, bits, ok_bfm);
            ok_all = ok_all & ok_bfm;
            if (a == 0) first_bits = bits;
        end
        wait_idle(int'(TMO), ok_idle);
        total++; if (!(ok_req && ok_all && ok_idle))
            $display("FAIL nack_handshake: got req=%b bus=%b idle=%b want 111", ok_req, ok_all, ok_idle); else passed++;
        total++; if (first_bits !== expected_frame(CMD_RESET))
            $display("FAIL nack_bits: got %b want %b", first_bits, expected_frame(CMD_RESET)); else passed++;
        total++; if (err_cnt - e0 != 1) $display("FAIL nack_error: got %0d pulses want 1", err_cnt - e0); else passed++;
        total++; if (done_cnt - d0 != 0) $display("FAIL nack_done: got %0d pulses want 0", done_cnt - d0); else passed++;
        total++; if (inhibit_phases - i0 != ATTEMPTS)
            $display("FAIL nack_inhibits: got %0d want %0d", inhibit_phases - i0, ATTEMPTS); else passed++;
        total++; if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001)
            $display("FAIL nack_release: got clk_oe,data_oe,ready=%b want 001", {ps2_clk_oe, ps2_data_oe, tx_ready}); else passed++;
    endtask

    task automatic test_timeout();
        int   d0, e0, i0;
        logic ok_req, ok_idle;
        d0 = done_cnt; e0 = err_cnt; i0 = inhibit_phases;
        send_req(CMD_ECHO, ok_req);
        wait_idle(ATTEMPTS * (int'(INH) + int'(TMO) + 100), ok_idle);
        total++; if (!(ok_req && ok_idle)) $display("FAIL timeout_handshake: got req=%b idle=%b want 11", ok_req, ok_idle); else passed++;
        total++; if (err_cnt - e0 != 1) $display("FAIL timeout_error: got %0d pulses want 1", err_cnt - e0); else passed++;
        total++; if (err_cyc - req_cyc != int'(TMO))
            $display("FAIL timeout_latency: got %0d cycles want %0d", err_cyc - req_cyc, TMO); else passed++;
        total++; if (done_cnt - d0 != 0) $display("FAIL timeout_done: got %0d pulses want 0", done_cnt - d0); else passed++;
        total++; if (inhibit_phases - i0 != ATTEMPTS)
            $display("FAIL timeout_inhibits: got %0d want %0d", inhibit_phases - i0, ATTEMPTS); else passed++;
        total++; if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001)
            $display("FAIL timeout_release: got clk_oe,data_oe,ready=%b want 001", {ps2_clk_oe, ps2_data_oe, tx_ready}); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int          d0, e0;
        logic [10:0] bits;
        logic        ok_req, ok_bfm;
        d0 = done_cnt; e0 = err_cnt;
        send_req(8'($urandom), ok_req);
        device_frame(30, 1'b1, 0, 5, bits, ok_bfm);
        total++; if (!(ok_req && ok_bfm && busy === 1'b1))
            $display("FAIL midrst_setup: got req=%b bus=%b busy=%b want 111", ok_req, ok_bfm, busy); else passed++;
        rst = 1'b1;
        @(negedge clk);
        total++; if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001)
            $display("FAIL midrst_release: got clk_oe,data_oe,ready=%b want 001", {ps2_clk_oe, ps2_data_oe, tx_ready}); else passed++;
        rst = 1'b0;
        dev_clk_low = 1'b0;
        repeat (60) @(negedge clk);
        total++; if ((done_cnt - d0) + (err_cnt - e0) != 0)
            $display("FAIL midrst_pulses: got done=%0d error=%0d want 0 0", done_cnt - d0, err_cnt - e0); else passed++;
        test_ack_frame(CMD_SET_LEDS, 0);
    endtask

    task automatic test_back_to_back();
        int          d0, i0, n, half;
        logic [7:0]  d;
        logic [10:0] bits1, bits2;
        logic        ok1, ok2, ok_idle;
        d = 8'($urandom);
        half = int'($urandom_range(25, 40));
        d0 = done_cnt; i0 = inhibit_phases;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        device_frame(half, 1'b1, 0, 0, bits1, ok1);
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        total++; if (busy !== 1'b0) $display("FAIL b2b_idle_gap: got busy=%b want 0", busy); else passed++;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = ~d;
        device_frame(half, 1'b1, 0, 0, bits2, ok2);
        wait_idle(int'(TMO), ok_idle);
        total++; if (!(ok1 && ok2 && ok_idle))
            $display("FAIL b2b_handshake: got %b%b%b want 111", ok1, ok2, ok_idle); else passed++;
        total++; if (bits1 !== expected_frame(d)) $display("FAIL b2b_bits1: got %b want %b", bits1, expected_frame(d)); else passed++;
        total++; if (bits2 !== expected_frame(d)) $display("FAIL b2b_bits2: got %b want %b", bits2, expected_frame(d)); else passed++;
        total++; if (done_cnt - d0 != 2) $display("FAIL b2b_done: got %0d pulses want 2", done_cnt - d0); else passed++;
        total++; if (inhibit_phases - i0 != 2) $display("FAIL b2b_inhibits: got %0d want 2", inhibit_phases - i0); else passed++;
    endtask

`ifdef PS2_HOST_TX_RETRY_EN
    task automatic test_retry();
        int          d0, e0, i0, half;
        logic [10:0] bits;
        logic        ok_req, ok_a, ok_b, ok_c, ok_idle;
        half = int'($urandom_range(25, 40));
        d0 = done_cnt; e0 = err_cnt; i0 = inhibit_phases;
        send_req(CMD_SET_LEDS, ok_req);
        device_frame(half, 1'b0, 0, 0, bits, ok_a);
        device_frame(half, 1'b0, 0, 0, bits, ok_b);
        device_frame(half, 1'b1, 0, 0, bits, ok_c);
        wait_idle(int'(TMO), ok_idle);
        total++; if (!(ok_req && ok_a && ok_b && ok_c && ok_idle))
            $display("FAIL retry_handshake: got %b%b%b%b%b want 11111", ok_req, ok_a, ok_b, ok_c, ok_idle); else passed++;
        total++; if (bits !== expected_frame(CMD_SET_LEDS))
            $display("FAIL retry_bits: got %b want %b", bits, expected_frame(CMD_SET_LEDS)); else passed++;
        total++; if (inhibit_phases - i0 != 3) $display("FAIL retry_inhibits: got %0d want 3", inhibit_phases - i0); else passed++;
        total++; if (done_cnt - d0 != 1) $display("FAIL retry_done: got %0d pulses want 1", done_cnt - d0); else passed++;
        total++; if (err_cnt - e0 != 0) $display("FAIL retry_error: got %0d pulses want 0", err_cnt - e0); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_ack_frame(CMD_SET_LEDS, 0);
        test_random_frames();
        test_glitch();
        test_nack();
        test_timeout();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef PS2_HOST_TX_RETRY_EN
        test_retry();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte per request to the keyboard, e.g. 0xFF reset or 0xED set-LEDs.
- Complements kb_interface, which receives device-to-host frames. Both share the ps2_clk/ps2_data open-drain lines through the top-level tri-state buffers.
- Runs in the clk65MHz domain.
- Asserts busy while it owns the bus, so kb_interface discards any frame seen during a transmission.

Parameters:
- INHIBIT_CYCLES, 7800: cycles ps2_clk is held low before the start bit (120 us at 65 MHz).
- TIMEOUT_CYCLES, 975000: maximum cycles from clock release to ack completion (15 ms).
- FILTER_LEN, 8: consecutive equal samples needed to accept a new ps2_clk level (glitch filter).

Ports:
- clk  in  1  system clock, clk65MHz
- rst  in  1  synchronous, active-high reset
- tx_data  in  8  command byte
- tx_valid  in  1  request; byte accepted when tx_valid && tx_ready
- tx_ready  out  1  high only in IDLE
- ps2_clk_in  in  1  raw ps2_clk pad level (asynchronous)
- ps2_data_in  in  1  raw ps2_data pad level (asynchronous)
- ps2_clk_oe  out  1  1 = drive ps2_clk low; 0 = release
- ps2_data_oe  out  1  1 = drive ps2_data low; 0 = release
- busy  out  1  high in every state except IDLE
- tx_done  out  1  one-cycle pulse: frame acked by the device
- tx_error  out  1  one-cycle pulse: timeout or missing ack

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high.
  - In reset: state IDLE, tx_ready=1, busy=0, both _oe=0, tx_done=0, tx_error=0, all counters cleared.
  - rst mid-frame releases both lines on the next edge; the aborted frame produces no pulse.
- Input conditioning: ps2_clk_in passes through a 2-flop synchronizer, then the FILTER_LEN filter. ps2_data_in passes through a 2-flop synchronizer only. A falling edge (fe) is a one-cycle strobe when the filtered clock goes 1->0.
- Frame: shift register {stop=1, parity, tx_data[7:0]} is loaded on accept. Parity is odd: ~^tx_data.
- State machine:
  - IDLE: tx_valid && tx_ready -> INHIBIT on the next cycle. tx_ready drops on that same edge.
  - INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_CYCLES cycles. The last cycle sets data_oe=1 (start bit), then -> REQ.
  - REQ: clk_oe=0, data_oe=1. Timeout counter starts. Each fe advances bit_cnt:
    - fe 1..8: data_oe = ~tx_data[bit_cnt-1], LSB first.
    - fe 9: data_oe = ~parity.
    - fe 10: data_oe=0 (stop bit, line released) -> ACK.
    - data_oe updates the cycle after the fe strobe.
  - ACK: on the next fe, sample synchronized data. 0 -> WAIT_IDLE; 1 -> FAIL.
  - WAIT_IDLE: wait until filtered clock=1 and data=1 -> DONE.
  - DONE: tx_done=1 for one cycle -> IDLE.
  - FAIL: both _oe=0, tx_error=1 for one cycle -> IDLE.
- Timeout: timeout counter >= TIMEOUT_CYCLES in REQ, ACK or WAIT_IDLE -> FAIL. The counter saturates; it never wraps.
- tx_valid held high after DONE starts a new frame from IDLE; at least one idle cycle separates frames.
- tx_data is sampled only at accept; later changes are ignored.
- ps2_clk_oe and ps2_data_oe are never both asserted outside INHIBIT's final cycle.

Optional Feature:
- PS2_HOST_TX_RETRY_EN defined: FAIL reloads the latched byte and returns to INHIBIT, up to 2 retries (3 attempts total). tx_error pulses only after the third failure. A 2-bit retry_cnt clears on accept and on reset.
- Undefined: the first failure goes directly to tx_error as described above.

Decomposition:
- Shared package ps2_pkg holds:
  - state encoding (IDLE, INHIBIT, REQ, ACK, WAIT_IDLE, DONE, FAIL)
  - command constants: CMD_RESET=8'hFF, CMD_SET_LEDS=8'hED, CMD_ECHO=8'hEE
  - ACK_BYTE=8'hFA
- kb_interface reuses ACK_BYTE from the package.
- Sub-module ps2_line_sync: 2-flop synchronizer, glitch filter and falling-edge strobe. It is reusable by kb_interface.

Test Plan:
- Request 0xED; the device BFM clocks at 12.5 kHz and acks -> ps2_clk low for 7800 cycles. Bits sampled by the BFM on rising edges: 0, 1,0,1,1,0,1,1,1, parity 1, stop 1. tx_done pulses once; busy falls after it.
- Request 0xFF with the BFM not acking (data high at fe 11) -> tx_error one pulse; both _oe=0; tx_ready=1.
- Request 0xEE with the BFM never clocking -> tx_error exactly TIMEOUT_CYCLES cycles after REQ entry (975000); lines released.
- 2-cycle glitch on ps2_clk_in mid-frame -> no bit advance; the frame completes correctly.
- rst asserted at fe 5 -> next cycle both _oe=0 and tx_ready=1; no tx_done or tx_error. A following 0xED request completes normally.
- With PS2_HOST_TX_RETRY_EN and the BFM nacking twice then acking -> three INHIBIT phases, one tx_done, no tx_error.
